// File: rtl/me_stage_unit_if.sv
// Pipeline handshake bundle around the ME stage: EX->ME request, ME->WB result,
// and the allow-in back-pressure on each side.
interface me_stage_unit_if #(
   parameter int unsigned EX_ME_W = 76,
   parameter int unsigned ME_WB_W = 70
);
   logic               EX_to_ME_Valid;
   logic [EX_ME_W-1:0] EX_to_ME_Bus;
   logic               ME_Allow_in;
   logic               WB_Allow_in;
   logic               ME_to_WB_Valid;
   logic [ME_WB_W-1:0] ME_to_WB_Bus;

   // master: the neighbouring EX/WB stages
   modport master (
      output EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in,
      input  ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus
   );

   // slave: the ME stage itself
   modport slave (
      input  EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in,
      output ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus
   );
endinterface

// File: rtl/me_stage_unit.sv
// ME stage: latches the EX bus, aligns/extends load data from the data SRAM and
// hands the result to WB; holds the SRAM read data across WB stalls.
module me_stage_unit (
   input  logic                 clk,
   input  logic                 reset,
   me_stage_unit_if.slave       pipe,
   input  logic [31:0]          data_sram_rdata,
   output logic [4:0]           ME_dest,
   output logic [31:0]          ME_Forward_Res,
   output logic                 ME_to_ID_Ld_op
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;

   typedef struct packed {
      logic              ld_sgn;
      logic              ld_b;
      logic              ld_h;
      logic [1:0]        off;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] alu_result;
      logic              res_from_mem;
      logic              gr_we;
      logic [REG_W-1:0]  dest;
   } ex_me_bus_t;

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] final_result;
      logic              gr_we;
      logic [REG_W-1:0]  dest;
   } me_wb_bus_t;

   logic              me_valid_q,   me_valid_d;
   ex_me_bus_t        bus_q,        bus_d;
   logic              fresh_q,      fresh_d;
   logic              hold_vld_q,   hold_vld_d;
   logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;

   ex_me_bus_t        ex_bus_c;
   logic              allow_in_c;
   logic              latch_c;
   logic [DATA_W-1:0] mem_data_c;
   logic [7:0]        byte_c;
   logic [15:0]       half_c;
   logic [DATA_W-1:0] load_c;
   logic [DATA_W-1:0] final_c;
   me_wb_bus_t        wb_bus_c;

   // Handshake: the stage always completes in one cycle, so only WB can stall it
   always_comb begin
      ex_bus_c   = pipe.EX_to_ME_Bus;
      allow_in_c = !me_valid_q || pipe.WB_Allow_in;
      latch_c    = allow_in_c && pipe.EX_to_ME_Valid;
   end

   // Next-state: the SRAM answers only in the cycle after issue, so grab it then if WB stalls
   always_comb begin
      me_valid_d   = me_valid_q;
      bus_d        = bus_q;
      fresh_d      = 1'b0;
      hold_vld_d   = hold_vld_q;
      rdata_hold_d = rdata_hold_q;

      if (allow_in_c) begin
         me_valid_d = pipe.EX_to_ME_Valid;
      end

      if (latch_c) begin
         bus_d      = ex_bus_c;
         fresh_d    = 1'b1;
         hold_vld_d = 1'b0;
      end else if (fresh_q && me_valid_q && !pipe.WB_Allow_in) begin
         hold_vld_d   = 1'b1;
         rdata_hold_d = data_sram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         me_valid_q   <= 1'b0;
         bus_q        <= '0;
         fresh_q      <= 1'b0;
         hold_vld_q   <= 1'b0;
         rdata_hold_q <= '0;
      end else begin
         me_valid_q   <= me_valid_d;
         bus_q        <= bus_d;
         fresh_q      <= fresh_d;
         hold_vld_q   <= hold_vld_d;
         rdata_hold_q <= rdata_hold_d;
      end
   end

   // Load alignment; byte wins over half, half ignores off[0]
   always_comb begin
      mem_data_c = hold_vld_q ? rdata_hold_q : data_sram_rdata;

      unique case (bus_q.off)
         2'd0:    byte_c = mem_data_c[7:0];
         2'd1:    byte_c = mem_data_c[15:8];
         2'd2:    byte_c = mem_data_c[23:16];
         default: byte_c = mem_data_c[31:24];
      endcase

      half_c = bus_q.off[1] ? mem_data_c[31:16] : mem_data_c[15:0];

      if (bus_q.ld_b) begin
         load_c = {{(DATA_W-8){bus_q.ld_sgn & byte_c[7]}}, byte_c};
      end else if (bus_q.ld_h) begin
         load_c = {{(DATA_W-16){bus_q.ld_sgn & half_c[15]}}, half_c};
      end else begin
         load_c = mem_data_c;
      end

      final_c = bus_q.res_from_mem ? load_c : bus_q.alu_result;
   end

   always_comb begin
      wb_bus_c.pc           = bus_q.pc;
      wb_bus_c.final_result = final_c;
      wb_bus_c.gr_we        = bus_q.gr_we;
      wb_bus_c.dest         = bus_q.dest;
   end

   assign pipe.ME_Allow_in    = allow_in_c;
   assign pipe.ME_to_WB_Valid = me_valid_q;
   assign pipe.ME_to_WB_Bus   = wb_bus_c;

   assign ME_dest        = bus_q.dest & {REG_W{me_valid_q}} & {REG_W{bus_q.gr_we}};
   assign ME_Forward_Res = final_c;
   assign ME_to_ID_Ld_op = me_valid_q & bus_q.res_from_mem;

endmodule

// File: tb/tb_me_stage_unit.sv
// Self-checking bench for me_stage_unit: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_me_stage_unit;

   logic        clk;
   logic        reset;
   logic [31:0] data_sram_rdata;
   logic [4:0]  ME_dest;
   logic [31:0] ME_Forward_Res;
   logic        ME_to_ID_Ld_op;

   int checks;
   int errors;

   me_stage_unit_if bus_if ();

   me_stage_unit u_dut (
      .clk             (clk),
      .reset           (reset),
      .pipe            (bus_if),
      .data_sram_rdata (data_sram_rdata),
      .ME_dest         (ME_dest),
      .ME_Forward_Res  (ME_Forward_Res),
      .ME_to_ID_Ld_op  (ME_to_ID_Ld_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus layout: {signed, byte, half, off[1:0], pc, alu_result, res_from_mem, gr_we, dest}
   function automatic logic [75:0] mk_bus(input logic s, input logic b, input logic h,
                                          input logic [1:0] off, input logic [31:0] pc,
                                          input logic [31:0] alu, input logic rfm,
                                          input logic we, input logic [4:0] dest);
      return {s, b, h, off, pc, alu, rfm, we, dest};
   endfunction

   // Reference load semantics expressed with shifts and masks
   function automatic logic [31:0] ref_load(input logic [4:0] flag, input logic [31:0] d);
      logic [31:0] v;
      int sh;
      sh = int'(flag[1:0]) * 8;
      if (flag[3]) begin
         v = (d >> sh) & 32'h0000_00FF;
         if (flag[4] && v[7]) v = v | 32'hFFFF_FF00;
      end else if (flag[2]) begin
         v = (flag[1] ? (d >> 16) : d) & 32'h0000_FFFF;
         if (flag[4] && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = d;
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bus_if.EX_to_ME_Valid = 1'b0;
      bus_if.WB_Allow_in    = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset                 = 1'b1;
      bus_if.EX_to_ME_Valid = 1'b1;
      bus_if.EX_to_ME_Bus   = mk_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h1C00_0000, 32'h1234, 1'b1, 1'b1, 5'd7);
      bus_if.WB_Allow_in    = 1'b1;
      data_sram_rdata       = 32'hDEAD_BEEF;
      tick();
      tick();
      checks += 4;
      if (bus_if.ME_to_WB_Valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b want 0", bus_if.ME_to_WB_Valid);
      end
      if (ME_dest !== 5'd0) begin
         errors++; $display("FAIL reset_dest: got %0d want 0", ME_dest);
      end
      if (ME_to_ID_Ld_op !== 1'b0) begin
         errors++; $display("FAIL reset_ldop: got %b want 0", ME_to_ID_Ld_op);
      end
      if (bus_if.ME_Allow_in !== 1'b1) begin
         errors++; $display("FAIL reset_allow: got %b want 1", bus_if.ME_Allow_in);
      end
      reset               = 1'b0;
      bus_if.EX_to_ME_Bus = mk_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h1C00_0004, 32'h1234, 1'b0, 1'b1, 5'd7);
      tick();
      bus_if.EX_to_ME_Valid = 1'b0;
      #1;
      checks += 3;
      if (bus_if.ME_to_WB_Valid !== 1'b1) begin
         errors++; $display("FAIL first_accept_valid: got %b want 1", bus_if.ME_to_WB_Valid);
      end
      if (ME_dest !== 5'd7) begin
         errors++; $display("FAIL first_accept_dest: got %0d want 7", ME_dest);
      end
      if (ME_Forward_Res !== 32'h1234) begin
         errors++; $display("FAIL first_accept_res: got %h want 00001234", ME_Forward_Res);
      end
      drain();
   endtask

   task automatic test_load_align();
      // {flag, rdata, expected}
      logic [4:0]  flags [7];
      logic [31:0] rdat  [7];
      logic [31:0] expv  [7];
      logic [69:0] wbv;
      flags[0] = 5'b11010; rdat[0] = 32'h1280_3456; expv[0] = 32'hFFFF_FF80; // ld.b  off2
      flags[1] = 5'b01010; rdat[1] = 32'h1280_3456; expv[1] = 32'h0000_0080; // ld.bu off2
      flags[2] = 5'b10110; rdat[2] = 32'h8001_7FFF; expv[2] = 32'hFFFF_8001; // ld.h  off2
      flags[3] = 5'b00100; rdat[3] = 32'h8001_7FFF; expv[3] = 32'h0000_7FFF; // ld.hu off0
      flags[4] = 5'b00000; rdat[4] = 32'h8001_7FFF; expv[4] = 32'h8001_7FFF; // ld.w
      flags[5] = 5'b11111; rdat[5] = 32'h9A00_1122; expv[5] = 32'hFFFF_FF9A; // b+h: byte wins, off3
      flags[6] = 5'b10101; rdat[6] = 32'h0000_F0AA; expv[6] = 32'hFFFF_F0AA; // ld.h off0[0] ignored
      for (int i = 0; i < 7; i++) begin
         bus_if.EX_to_ME_Valid = 1'b1;
         bus_if.EX_to_ME_Bus   = mk_bus(flags[i][4], flags[i][3], flags[i][2], flags[i][1:0],
                                        32'h1C00_0100 + 32'(i * 4), 32'h0000_1000, 1'b1, 1'b1, 5'(i + 1));
         bus_if.WB_Allow_in    = 1'b1;
         tick();
         bus_if.EX_to_ME_Valid = 1'b0;
         data_sram_rdata       = rdat[i];
         #1;
         wbv = bus_if.ME_to_WB_Bus;
         checks += 3;
         if (ME_Forward_Res !== expv[i]) begin
            errors++; $display("FAIL load_align[%0d] fwd: got %h want %h", i, ME_Forward_Res, expv[i]);
         end
         if (wbv[37:6] !== expv[i]) begin
            errors++; $display("FAIL load_align[%0d] wb: got %h want %h", i, wbv[37:6], expv[i]);
         end
         if (ME_to_ID_Ld_op !== 1'b1) begin
            errors++; $display("FAIL load_align[%0d] ldop: got %b want 1", i, ME_to_ID_Ld_op);
         end
         tick();
      end
      drain();
   endtask

   task automatic test_stall_hold();
      int xfers;
      xfers = 0;
      bus_if.EX_to_ME_Valid = 1'b1;
      bus_if.EX_to_ME_Bus   = mk_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h1C00_0200, 32'h0, 1'b1, 1'b1, 5'd9);
      bus_if.WB_Allow_in    = 1'b1;
      tick();
      bus_if.EX_to_ME_Valid = 1'b0;
      bus_if.WB_Allow_in    = 1'b0;
      data_sram_rdata       = 32'hAABB_CCDD;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks += 2;
         if (bus_if.ME_Allow_in !== 1'b0) begin
            errors++; $display("FAIL stall_allow[%0d]: got %b want 0", c, bus_if.ME_Allow_in);
         end
         if (ME_Forward_Res !== 32'hAABB_CCDD) begin
            errors++; $display("FAIL stall_data[%0d]: got %h want aabbccdd", c, ME_Forward_Res);
         end
         tick();
         data_sram_rdata = 32'h1111_1111;
      end
      bus_if.WB_Allow_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (c == 0) begin
            checks++;
            if (ME_Forward_Res !== 32'hAABB_CCDD) begin
               errors++; $display("FAIL stall_release_data: got %h want aabbccdd", ME_Forward_Res);
            end
         end
         if (bus_if.ME_to_WB_Valid && bus_if.WB_Allow_in) xfers++;
         tick();
      end
      checks++;
      if (xfers !== 1) begin
         errors++; $display("FAIL stall_xfers: got %0d want 1", xfers);
      end
   endtask

   task automatic test_back_to_back();
      bus_if.EX_to_ME_Valid = 1'b1;
      bus_if.EX_to_ME_Bus   = mk_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h1C00_0300, 32'd5, 1'b0, 1'b1, 5'd3);
      bus_if.WB_Allow_in    = 1'b1;
      tick();
      bus_if.EX_to_ME_Bus   = mk_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h1C00_0304, 32'h100, 1'b1, 1'b1, 5'd4);
      data_sram_rdata       = 32'h5555_5555;
      #1;
      checks += 4;
      if (ME_dest !== 5'd3) begin
         errors++; $display("FAIL b2b_add_dest: got %0d want 3", ME_dest);
      end
      if (ME_Forward_Res !== 32'd5) begin
         errors++; $display("FAIL b2b_add_res: got %h want 00000005", ME_Forward_Res);
      end
      if (ME_to_ID_Ld_op !== 1'b0) begin
         errors++; $display("FAIL b2b_add_ldop: got %b want 0", ME_to_ID_Ld_op);
      end
      if (bus_if.ME_Allow_in !== 1'b1) begin
         errors++; $display("FAIL b2b_allow: got %b want 1", bus_if.ME_Allow_in);
      end
      tick();
      bus_if.EX_to_ME_Valid = 1'b0;
      data_sram_rdata       = 32'h0000_0077;
      #1;
      checks += 4;
      if (bus_if.ME_to_WB_Valid !== 1'b1) begin
         errors++; $display("FAIL b2b_ld_valid: got %b want 1", bus_if.ME_to_WB_Valid);
      end
      if (ME_to_ID_Ld_op !== 1'b1) begin
         errors++; $display("FAIL b2b_ld_ldop: got %b want 1", ME_to_ID_Ld_op);
      end
      if (ME_dest !== 5'd4) begin
         errors++; $display("FAIL b2b_ld_dest: got %0d want 4", ME_dest);
      end
      if (ME_Forward_Res !== 32'h77) begin
         errors++; $display("FAIL b2b_ld_res: got %h want 00000077", ME_Forward_Res);
      end
      drain();
   endtask

   task automatic test_reset_mid_stall();
      bus_if.EX_to_ME_Valid = 1'b1;
      bus_if.EX_to_ME_Bus   = mk_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h1C00_0400, 32'h0, 1'b1, 1'b1, 5'd12);
      bus_if.WB_Allow_in    = 1'b1;
      tick();
      bus_if.EX_to_ME_Valid = 1'b0;
      bus_if.WB_Allow_in    = 1'b0;
      data_sram_rdata       = 32'hCAFE_F00D;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks += 3;
      if (bus_if.ME_to_WB_Valid !== 1'b0) begin
         errors++; $display("FAIL rst_stall_valid: got %b want 0", bus_if.ME_to_WB_Valid);
      end
      if (bus_if.ME_Allow_in !== 1'b1) begin
         errors++; $display("FAIL rst_stall_allow: got %b want 1", bus_if.ME_Allow_in);
      end
      if (ME_dest !== 5'd0) begin
         errors++; $display("FAIL rst_stall_dest: got %0d want 0", ME_dest);
      end
      bus_if.EX_to_ME_Valid = 1'b1;
      bus_if.EX_to_ME_Bus   = mk_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h1C00_0408, 32'h0, 1'b1, 1'b1, 5'd13);
      bus_if.WB_Allow_in    = 1'b1;
      tick();
      bus_if.EX_to_ME_Valid = 1'b0;
      data_sram_rdata       = 32'h5A5A_5A5A;
      #1;
      checks++;
      if (ME_Forward_Res !== 32'h5A5A_5A5A) begin
         errors++; $display("FAIL rst_stall_live: got %h want 5a5a5a5a", ME_Forward_Res);
      end
      drain();
   endtask

   task automatic test_random();
      logic        mv;
      logic [75:0] mi;
      logic [31:0] md;
      logic        need;
      logic        ev, wb;
      logic [75:0] eb;
      logic [31:0] rd, exp_res;
      logic [69:0] wbv;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mv = 1'b0; mi = '0; md = '0; need = 1'b0;
      for (int c = 0; c < 600; c++) begin
         ev = ($urandom_range(0, 9) < 7);
         wb = ($urandom_range(0, 9) < 6);
         eb = {$urandom(), $urandom(), 12'($urandom())};
         rd = $urandom();
         bus_if.EX_to_ME_Valid = ev;
         bus_if.EX_to_ME_Bus   = eb;
         bus_if.WB_Allow_in    = wb;
         data_sram_rdata       = rd;
         if (need) begin
            md   = rd;
            need = 1'b0;
         end
         #1;
         checks += 4;
         if (bus_if.ME_Allow_in !== (!mv || wb)) begin
            errors++; $display("FAIL rand[%0d] allow: got %b want %b", c, bus_if.ME_Allow_in, !mv || wb);
         end
         if (bus_if.ME_to_WB_Valid !== mv) begin
            errors++; $display("FAIL rand[%0d] valid: got %b want %b", c, bus_if.ME_to_WB_Valid, mv);
         end
         if (ME_to_ID_Ld_op !== (mv & mi[6])) begin
            errors++; $display("FAIL rand[%0d] ldop: got %b want %b", c, ME_to_ID_Ld_op, mv & mi[6]);
         end
         if (ME_dest !== ((mv && mi[5]) ? mi[4:0] : 5'd0)) begin
            errors++; $display("FAIL rand[%0d] dest: got %0d want %0d", c, ME_dest,
                               (mv && mi[5]) ? mi[4:0] : 5'd0);
         end
         if (mv) begin
            exp_res = mi[6] ? ref_load(mi[75:71], md) : mi[38:7];
            wbv     = bus_if.ME_to_WB_Bus;
            checks += 2;
            if (wbv !== {mi[70:39], exp_res, mi[5], mi[4:0]}) begin
               errors++; $display("FAIL rand[%0d] wb_bus: got %h want %h", c, wbv,
                                  {mi[70:39], exp_res, mi[5], mi[4:0]});
            end
            if (ME_Forward_Res !== exp_res) begin
               errors++; $display("FAIL rand[%0d] fwd: got %h want %h", c, ME_Forward_Res, exp_res);
            end
         end
         if (!mv || wb) begin
            mv = ev;
            if (ev) begin
               mi   = eb;
               need = 1'b1;
            end
         end
         tick();
      end
      drain();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset                 = 1'b1;
      bus_if.EX_to_ME_Valid = 1'b0;
      bus_if.EX_to_ME_Bus   = '0;
      bus_if.WB_Allow_in    = 1'b1;
      data_sram_rdata       = '0;
      test_reset();
      test_load_align();
      test_stall_hold();
      test_back_to_back();
      test_reset_mid_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/me_stage_unit.md
Name: me_stage_unit

Overview:
- Memory-access (ME) pipeline stage of the 5-stage LoongArch core, sitting between EX and WB.
- Receives the EX_to_ME bus, consumes the synchronous data-SRAM read response for the load that EX issued, and aligns and extends load data (byte/half/word, signed/unsigned).
- Forwards the final result to WB, plus a dest/result forwarding pair to ID.
- Captures SRAM read data when stalled, because the SRAM address changes every cycle.

Parameters:
- EX_ME_W, 76, EX_to_ME bus width.
- ME_WB_W, 70, ME_to_WB bus width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- EX_to_ME_Valid  input  1  EX holds a valid instruction for ME
- EX_to_ME_Bus  input  76  [75:71] flag {signed, byte, half, off[1:0]}; [70:39] pc; [38:7] alu_result; [6] res_from_mem; [5] gr_we; [4:0] dest
- ME_Allow_in  output  1  ME can accept an instruction this cycle
- data_sram_rdata  input  32  SRAM read data, valid the cycle after EX presented the address
- WB_Allow_in  input  1  WB can accept
- ME_to_WB_Valid  output  1  ME bus valid
- ME_to_WB_Bus  output  70  [69:38] pc; [37:6] final_result; [5] gr_we; [4:0] dest
- ME_dest  output  5  dest & {5{ME_Valid}} & {5{gr_we}}
- ME_Forward_Res  output  32  final_result
- ME_to_ID_Ld_op  output  1  ME_Valid & res_from_mem

Behaviour:
Handshake:
- ME_ReadyGo = 1.
- ME_Allow_in = !ME_Valid || WB_Allow_in.
- ME_to_WB_Valid = ME_Valid.
- On a clk edge with ME_Allow_in: ME_Valid <= EX_to_ME_Valid.
- On a clk edge with ME_Allow_in && EX_to_ME_Valid: latch the entire bus into internal registers.
- Simultaneous leave/enter: the old instruction leaves and the new one is latched in the same edge, with no bubble.

Reset:
- ME_Valid = 0; all latched bus fields = 0; hold_vld = 0; fresh = 0.
- Therefore ME_to_WB_Valid = 0, ME_dest = 0, ME_to_ID_Ld_op = 0, ME_Allow_in = 1.
- Reset asserted mid-stall drops the instruction and its held data.

Read-data capture:
- fresh is set for the first cycle after an instruction is latched; it is cleared on the next edge.
- If fresh && ME_Valid && !WB_Allow_in: rdata_hold <= data_sram_rdata and hold_vld <= 1.
- hold_vld is cleared whenever a new instruction is latched, and on reset.
- mem_data = hold_vld ? rdata_hold : data_sram_rdata.
- A stall of N cycles must deliver the data from the fresh cycle, not later SRAM output.

Load alignment (flag = {s, b, h, off}):
- b=1: byte = mem_data[8*off+7 : 8*off]; zero- or sign-extended by s.
- b=0, h=1: half = off[1] ? [31:16] : [15:0]; extended by s. off[0] is ignored (misalignment is not handled here).
- b=0, h=0: full word.
- b=1 && h=1: byte takes priority.
- final_result = res_from_mem ? aligned load : alu_result.

Stores and ALU ops:
- res_from_mem = 0; the result is alu_result unchanged.
- rdata is ignored but hold capture still fires harmlessly.

Forwarding outputs are combinational from the latched state and the current mem_data.

No internal latency beyond the one-register stage: an instruction latched at edge k is presented to WB in cycle k+1 if WB_Allow_in.

Test Plan:
- Reset held 2 cycles, then released → ME_to_WB_Valid=0, ME_dest=0, ME_Allow_in=1; after release, first valid bus is accepted on the next edge.
- ld.b signed, off=2, rdata=0x12_80_34_56, WB ready → final_result=0xFFFFFF80; ld.bu with the same inputs → 0x00000080.
- ld.h signed, off=2, rdata=0x8001_7FFF → 0xFFFF8001; ld.hu with off=0 → 0x00007FFF; ld.w → 0x80017FFF.
- Load enters with rdata=0xAABBCCDD, WB_Allow_in=0 for 3 cycles while rdata changes to 0x11111111 → ME_Allow_in=0 during the stall; on release, final_result=0xAABBCCDD (word), and exactly one WB transfer occurs.
- Back-to-back add (alu_result=5, dest=3, gr_we=1) then load with continuous ready → ME_dest=3, ME_Forward_Res=5, ME_to_ID_Ld_op=0, then ME_to_ID_Ld_op=1 the next cycle; no bubble.
- Reset asserted during the stalled load from the previous scenario → next cycle ME_Valid=0 and hold_vld=0; a subsequent ld.w returns live rdata.
